// File: rtl/udp_icache_loader.sv
// udp_icache_loader: capture-and-drain buffer between the UDP receive core and
// the instruction-cache fill path. Rising edges of word_valid write payload
// words into an internal RAM; rx_finish commits the frame, after which up to
// READ_LEN words (all of them when READ_LEN==0) are streamed out over a
// valid/ready interface with back-pressure.
//
// Optional feature: define ICACHE_LOADER_CSUM_EN to add the csum output, a
// running ones-complement sum of the 16-bit half-words of every stored word.
//
// Ports:
//   E_RXC        receive clock (only clock)
//   rst          synchronous active-high reset
//   word_valid   level strobe; each 0->1 transition delivers one word
//   word_data    payload word, sampled when the rise is detected
//   rx_finish    one-cycle end-of-frame pulse
//   out_valid    drain word valid
//   out_data     drain word
//   out_addr     RAM index of out_data
//   out_ready    consumer accept (out_valid && out_ready)
//   frame_words  word count of the last committed frame
//   busy         state is not IDLE (combinational)
//   overflow     sticky: a word was dropped in the current or last frame
//   done         one-cycle pulse after the last drain word is accepted
//   csum         ones-complement half-word sum (ICACHE_LOADER_CSUM_EN only)
module udp_icache_loader #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DEPTH    = 512,
  parameter int unsigned READ_LEN = 16,
  parameter int unsigned AW       = $clog2(DEPTH)
) (
  input  logic              E_RXC,
  input  logic              rst,
  input  logic              word_valid,
  input  logic [DATA_W-1:0] word_data,
  input  logic              rx_finish,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [AW-1:0]     out_addr,
  input  logic              out_ready,
  output logic [AW:0]       frame_words,
  output logic              busy,
  output logic              overflow,
  output logic              done
`ifdef ICACHE_LOADER_CSUM_EN
  ,
  output logic [15:0]       csum
`endif
);

  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  // Effective drain cap; READ_LEN of 0 or >= DEPTH never limits the frame.
  localparam logic [CW-1:0] RL_C =
    (READ_LEN == 0 || READ_LEN >= DEPTH) ? DEPTH_C : CW'(READ_LEN);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CAPTURE = 2'd1;
  localparam logic [1:0] S_DRAIN   = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_nxt;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              prev;
  logic              rise;
  logic [CW-1:0]     wr_ptr;
  logic              wr_room;
  logic              wr_en;
  logic [CW-1:0]     fw_commit;
  logic [CW-1:0]     n_commit;

  logic [CW-1:0]     rd_ptr;
  logic [CW-1:0]     drain_len;
  logic              rd_issue;
  logic              s1_valid;
  logic [DATA_W-1:0] s1_data;
  logic [AW-1:0]     s1_addr;
  logic              out_adv;
  logic              fire;
  logic              last_fire;

  // Strobe edge detect: a level held high counts as one word.
  assign rise    = word_valid & ~prev;
  assign wr_room = (wr_ptr < DEPTH_C);
  assign wr_en   = rise && ((state == S_IDLE) || ((state == S_CAPTURE) && wr_room));

  // Output register can take a new word when empty or being accepted.
  assign out_adv   = !out_valid || out_ready;
  assign fire      = out_valid && out_ready;
  assign last_fire = (state == S_DRAIN) && fire &&
                     (out_addr == AW'(drain_len - CW'(1)));
  // Read stage refills when it is empty or draining into the output register.
  assign rd_issue  = (state == S_DRAIN) && (rd_ptr < drain_len) &&
                     (!s1_valid || out_adv);

  assign busy = (state != S_IDLE);

  // Commit length: a rise coincident with rx_finish is counted if it fits.
  always_comb begin
    fw_commit = wr_ptr;
    if (rise && wr_room) fw_commit = wr_ptr + CW'(1);
    n_commit = fw_commit;
    if (fw_commit > RL_C) n_commit = RL_C;
  end

  // State register.
  always_ff @(posedge E_RXC) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (rise)      state_nxt = S_CAPTURE;
      S_CAPTURE: if (rx_finish) state_nxt = S_DRAIN;
      S_DRAIN:   if (last_fire) state_nxt = S_IDLE;
      default:                  state_nxt = S_IDLE;
    endcase
  end

  // Payload RAM: one write port, registered read port with enable.
  always_ff @(posedge E_RXC) begin
    if (wr_en)    mem[wr_ptr[AW-1:0]] <= word_data;
    if (rd_issue) s1_data <= mem[rd_ptr[AW-1:0]];
  end

  // Capture pointers, commit bookkeeping and drain pipeline.
  always_ff @(posedge E_RXC) begin
    if (rst) begin
      prev        <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      drain_len   <= '0;
      s1_valid    <= 1'b0;
      s1_addr     <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_addr    <= '0;
      frame_words <= '0;
      overflow    <= 1'b0;
      done        <= 1'b0;
    end else begin
      prev <= word_valid;
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rise) begin
            wr_ptr   <= CW'(1);
            overflow <= 1'b0;
          end
        end
        S_CAPTURE: begin
          if (rise) begin
            if (wr_room) wr_ptr <= wr_ptr + CW'(1);
            else         overflow <= 1'b1;
          end
          if (rx_finish) begin
            frame_words <= fw_commit;
            drain_len   <= n_commit;
            rd_ptr      <= '0;
            s1_valid    <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (rise) overflow <= 1'b1;
          if (rd_issue) begin
            rd_ptr   <= rd_ptr + CW'(1);
            s1_addr  <= rd_ptr[AW-1:0];
            s1_valid <= 1'b1;
          end else if (out_adv) begin
            s1_valid <= 1'b0;
          end
          if (out_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
              out_data <= s1_data;
              out_addr <= s1_addr;
            end
          end
          if (last_fire) begin
            out_valid <= 1'b0;
            s1_valid  <= 1'b0;
            done      <= 1'b1;
            wr_ptr    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ICACHE_LOADER_CSUM_EN
  localparam int unsigned NH = DATA_W / 16;

  logic              cs_pend;
  logic [DATA_W-1:0] cs_word;

  function automatic logic [15:0] oc_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + 16'(s[16]);
  endfunction

  function automatic logic [15:0] oc_sum_word(input logic [15:0] acc,
                                              input logic [DATA_W-1:0] w);
    logic [15:0] r;
    r = acc;
    for (int unsigned i = 0; i < NH; i++) r = oc_add(r, w[16*i +: 16]);
    return r;
  endfunction

  // Checksum trails each stored word by one cycle; cleared on a frame's first word.
  always_ff @(posedge E_RXC) begin
    if (rst) begin
      cs_pend <= 1'b0;
      cs_word <= '0;
      csum    <= '0;
    end else begin
      cs_pend <= wr_en;
      if (wr_en) cs_word <= word_data;
      if ((state == S_IDLE) && rise) csum <= '0;
      else if (cs_pend)              csum <= oc_sum_word(csum, cs_word);
    end
  end
`endif

endmodule

// File: tb/tb_udp_icache_loader.sv
// Scoreboard bench for udp_icache_loader. Two instances share stimulus: the
// default configuration (DEPTH 512, READ_LEN 16) and a small one (DEPTH 8,
// READ_LEN 0). A frame-level model pushes expected drain beats per instance;
// a negedge monitor pops and compares every accepted beat.
module tb_udp_icache_loader;

  localparam int unsigned D0 = 512;
  localparam int unsigned R0 = 16;
  localparam int unsigned A0 = 9;
  localparam int unsigned D1 = 8;
  localparam int unsigned R1 = 0;
  localparam int unsigned A1 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        word_valid;
  logic [31:0] word_data;
  logic        rx_finish;
  logic        out_ready;

  logic        ov0, busy0, of0, dn0;
  logic [31:0] od0;
  logic [A0-1:0] oa0;
  logic [A0:0] fw0;
  logic        ov1, busy1, of1, dn1;
  logic [31:0] od1;
  logic [A1-1:0] oa1;
  logic [A1:0] fw1;
`ifdef ICACHE_LOADER_CSUM_EN
  logic [15:0] cs0, cs1;
`endif

  udp_icache_loader #(.DATA_W(32), .DEPTH(D0), .READ_LEN(R0)) dut0 (
    .E_RXC(clk), .rst(rst), .word_valid(word_valid), .word_data(word_data),
    .rx_finish(rx_finish), .out_valid(ov0), .out_data(od0), .out_addr(oa0),
    .out_ready(out_ready), .frame_words(fw0), .busy(busy0), .overflow(of0),
    .done(dn0)
`ifdef ICACHE_LOADER_CSUM_EN
    , .csum(cs0)
`endif
  );

  udp_icache_loader #(.DATA_W(32), .DEPTH(D1), .READ_LEN(R1)) dut1 (
    .E_RXC(clk), .rst(rst), .word_valid(word_valid), .word_data(word_data),
    .rx_finish(rx_finish), .out_valid(ov1), .out_data(od1), .out_addr(oa1),
    .out_ready(out_ready), .frame_words(fw1), .busy(busy1), .overflow(of1),
    .done(dn1)
`ifdef ICACHE_LOADER_CSUM_EN
    , .csum(cs1)
`endif
  );

  typedef struct packed {
    logic [31:0] data;
    logic [15:0] addr;
  } beat_t;

  int checks = 0;
  int errors = 0;

  beat_t       q0[$];
  beat_t       q1[$];
  logic [31:0] pend[$];
  logic [31:0] fr[$];

  int          beats[2];
  int          dones[2];
  logic        st_v[2];
  logic [31:0] st_d[2];
  logic [15:0] st_a[2];

  int          exp_fw[2];
  int          exp_n[2];
  bit          exp_of[2];
  int          exp_cs[2];

  int ready_mode = 0;
  int rcnt = 0;

  task automatic chk(input string name, input int id, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d actual=%0h required=%0h", name, id, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Frame-level reference: which words survive, how many drain, checksum.
  function automatic void model_commit(input bit inject);
    int d, r, fw, n;
    longint s;
    for (int id = 0; id < 2; id++) begin
      d  = (id == 0) ? int'(D0) : int'(D1);
      r  = (id == 0) ? int'(R0) : int'(R1);
      fw = (fr.size() < d) ? fr.size() : d;
      n  = (r == 0 || fw < r) ? fw : r;
      exp_fw[id] = fw;
      exp_n[id]  = n;
      exp_of[id] = (fr.size() > d) || inject;
      s = 0;
      for (int i = 0; i < fw; i++) s += longint'(fr[i][15:0]) + longint'(fr[i][31:16]);
      while ((s >> 16) != 0) s = (s & 64'hFFFF) + (s >> 16);
      exp_cs[id] = int'(s);
      for (int i = 0; i < n; i++) begin
        if (id == 0) q0.push_back({fr[i], 16'(i)});
        else         q1.push_back({fr[i], 16'(i)});
      end
    end
  endfunction

  task automatic check_reset_outputs();
    chk("rst_valid", 0, 64'(ov0), 0);   chk("rst_valid", 1, 64'(ov1), 0);
    chk("rst_data", 0, 64'(od0), 0);    chk("rst_data", 1, 64'(od1), 0);
    chk("rst_addr", 0, 64'(oa0), 0);    chk("rst_addr", 1, 64'(oa1), 0);
    chk("rst_fw", 0, 64'(fw0), 0);      chk("rst_fw", 1, 64'(fw1), 0);
    chk("rst_busy", 0, 64'(busy0), 0);  chk("rst_busy", 1, 64'(busy1), 0);
    chk("rst_ovf", 0, 64'(of0), 0);     chk("rst_ovf", 1, 64'(of1), 0);
    chk("rst_done", 0, 64'(dn0), 0);    chk("rst_done", 1, 64'(dn1), 0);
`ifdef ICACHE_LOADER_CSUM_EN
    chk("rst_csum", 0, 64'(cs0), 0);    chk("rst_csum", 1, 64'(cs1), 0);
`endif
  endtask

  // Sends pend[] as one frame, commits it and (unless aborted) waits for both drains.
  task automatic run_frame(input bit coincide, input int hold, input bit inject,
                           input int rmode, input bit abort);
    int db0, db1, bb0, bb1, cyc;
    ready_mode = rmode;
    fr.delete();
    db0 = dones[0]; db1 = dones[1];
    bb0 = beats[0]; bb1 = beats[1];
    for (int i = 0; i < pend.size(); i++) begin
      if (coincide && i == pend.size() - 1) break;
      word_valid = 1'b1;
      word_data  = pend[i];
      fr.push_back(pend[i]);
      step();
      for (int k = 1; k < ((i == 0) ? hold : 1); k++) begin
        word_data = $urandom;
        step();
      end
      word_valid = 1'b0;
      repeat ($urandom_range(1, 2)) step();
    end
    if (coincide) begin
      word_valid = 1'b1;
      word_data  = pend[pend.size() - 1];
      fr.push_back(pend[pend.size() - 1]);
    end
    rx_finish = 1'b1;
    model_commit(inject);
    step();
    rx_finish  = 1'b0;
    word_valid = 1'b0;
    step();
    chk("lat1_valid", 0, 64'(ov0), 0); chk("lat1_valid", 1, 64'(ov1), 0);
    step();
    chk("lat2_valid", 0, 64'(ov0), 1); chk("lat2_valid", 1, 64'(ov1), 1);
    if (abort) begin
      step(); step();
      rst = 1'b1;
      step();
      check_reset_outputs();
      rst = 1'b0;
      q0.delete();
      q1.delete();
      return;
    end
    if (inject) begin
      word_valid = 1'b1;
      word_data  = $urandom;
      step();
      word_valid = 1'b0;
      step();
    end
    cyc = 0;
    while ((busy0 || busy1) && cyc < 3000) begin
      step();
      cyc++;
    end
    if (busy0 || busy1) begin
      checks++; errors++;
      $display("FAIL drain_timeout busy0=%0b busy1=%0b", busy0, busy1);
    end
    step();
    chk("frame_words", 0, 64'(fw0), 64'(exp_fw[0]));
    chk("frame_words", 1, 64'(fw1), 64'(exp_fw[1]));
    chk("overflow", 0, 64'(of0), 64'(exp_of[0]));
    chk("overflow", 1, 64'(of1), 64'(exp_of[1]));
    chk("done_count", 0, 64'(dones[0] - db0), 1);
    chk("done_count", 1, 64'(dones[1] - db1), 1);
    chk("beat_count", 0, 64'(beats[0] - bb0), 64'(exp_n[0]));
    chk("beat_count", 1, 64'(beats[1] - bb1), 64'(exp_n[1]));
    chk("queue_left", 0, 64'(q0.size()), 0);
    chk("queue_left", 1, 64'(q1.size()), 0);
`ifdef ICACHE_LOADER_CSUM_EN
    chk("csum", 0, 64'(cs0), 64'(exp_cs[0]));
    chk("csum", 1, 64'(cs1), 64'(exp_cs[1]));
`endif
  endtask

  // Consumer ready: always, 1-0-0 pattern, or random.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1: begin out_ready = ((rcnt % 3) == 0); rcnt++; end
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic mon(input int id, input logic v, input logic [31:0] d,
                     input logic [15:0] a, input logic dn, input logic bz);
    beat_t e;
    if (st_v[id]) begin
      chk("stall_valid", id, 64'(v), 1);
      chk("stall_data", id, 64'(d), 64'(st_d[id]));
      chk("stall_addr", id, 64'(a), 64'(st_a[id]));
    end
    if (v && out_ready) begin
      if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) begin
        checks++; errors++;
        $display("FAIL extra_beat dut%0d data=%0h addr=%0d", id, d, a);
      end else begin
        e = (id == 0) ? q0.pop_front() : q1.pop_front();
        chk("beat_data", id, 64'(d), 64'(e.data));
        chk("beat_addr", id, 64'(a), 64'(e.addr));
      end
      beats[id]++;
    end
    if (dn) begin
      dones[id]++;
      chk("done_busy", id, 64'(bz), 0);
      chk("done_valid", id, 64'(v), 0);
    end
    st_v[id] = v && !out_ready;
    st_d[id] = d;
    st_a[id] = a;
  endtask

  // Monitor: compares every accepted beat against the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      st_v[0] = 1'b0;
      st_v[1] = 1'b0;
    end else begin
      mon(0, ov0, od0, 16'(oa0), dn0, busy0);
      mon(1, ov1, od1, 16'(oa1), dn1, busy1);
    end
  end

  initial begin
    int fwb0, fwb1, db0, db1, len;
    beats[0] = 0; beats[1] = 0; dones[0] = 0; dones[1] = 0;
    st_v[0] = 1'b0; st_v[1] = 1'b0;
    rst = 1'b1; word_valid = 1'b0; word_data = '0; rx_finish = 1'b0;
    step(); step();
    check_reset_outputs();
    rst = 1'b0;
    step();

    // 20 sequential words, full-rate consumer.
    pend.delete();
    for (int i = 0; i < 20; i++) pend.push_back(32'h1000_0000 + 32'(i));
    run_frame(1'b0, 1, 1'b0, 0, 1'b0);
    chk("fw_20", 0, 64'(fw0), 20);
    chk("fw_cap8", 1, 64'(fw1), 8);

    // 10 words under the 1,0,0 ready pattern; small instance overflows.
    pend.delete();
    for (int i = 0; i < 10; i++) pend.push_back($urandom);
    run_frame(1'b0, 1, 1'b0, 1, 1'b0);
    chk("ovf_small", 1, 64'(of1), 1);
    chk("no_ovf_big", 0, 64'(of0), 0);

    // Strobe held high five cycles counts once.
    pend.delete();
    pend.push_back($urandom);
    run_frame(1'b0, 5, 1'b0, 2, 1'b0);
    chk("fw_hold", 0, 64'(fw0), 1);

    // Rise coincident with rx_finish after three words.
    pend.delete();
    for (int i = 0; i < 4; i++) pend.push_back($urandom);
    run_frame(1'b1, 1, 1'b0, 2, 1'b0);
    chk("fw_coinc", 0, 64'(fw0), 4);

    // rx_finish in IDLE is ignored.
    fwb0 = int'(fw0); fwb1 = int'(fw1); db0 = dones[0]; db1 = dones[1];
    rx_finish = 1'b1;
    step();
    rx_finish = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("idle_busy", 0, 64'(busy0), 0);
      chk("idle_busy", 1, 64'(busy1), 0);
      step();
    end
    chk("idle_done", 0, 64'(dones[0] - db0), 0);
    chk("idle_done", 1, 64'(dones[1] - db1), 0);
    chk("idle_fw", 0, 64'(fw0), 64'(fwb0));
    chk("idle_fw", 1, 64'(fw1), 64'(fwb1));

    // Checksum example frame.
    pend.delete();
    pend.push_back(32'h0001_FFFF);
    pend.push_back(32'h0002_0000);
    run_frame(1'b0, 1, 1'b0, 0, 1'b0);
`ifdef ICACHE_LOADER_CSUM_EN
    chk("csum_example", 0, 64'(cs0), 64'h3);
`endif

    // Word arriving during drain is dropped and flags overflow.
    pend.delete();
    for (int i = 0; i < 12; i++) pend.push_back($urandom);
    run_frame(1'b0, 1, 1'b1, 2, 1'b0);

    // Randomised frames.
    for (int f = 0; f < 10; f++) begin
      len = $urandom_range(2, 20);
      pend.delete();
      for (int i = 0; i < len; i++) pend.push_back($urandom);
      run_frame(1'($urandom_range(0, 1)), $urandom_range(1, 3), 1'b0,
                $urandom_range(0, 2), 1'b0);
    end

    // Reset mid-drain, then a normal frame.
    pend.delete();
    for (int i = 0; i < 12; i++) pend.push_back($urandom);
    run_frame(1'b0, 1, 1'b0, 1, 1'b1);
    step();
    pend.delete();
    for (int i = 0; i < 5; i++) pend.push_back($urandom);
    run_frame(1'b0, 1, 1'b0, 2, 1'b0);
    chk("post_rst_fw", 0, 64'(fw0), 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/udp_icache_loader.md
Name: udp_icache_loader

Overview:
Parametrised capture-and-drain buffer between the UDP receive core and the instruction-cache fill path. It writes one payload word into an internal RAM on each rising edge of the word strobe. On end-of-frame it commits the frame, then streams the stored words out over a valid/ready interface. Depth, word width and readout length are generic. It adds overflow detection, a committed-frame word count and back-pressure, none of which the current fixed 16-word readout has.

Parameters:
DATA_W, 32, payload word width in bits; must be ≥8.
DEPTH, 512, RAM depth in words; power of two, ≥4.
READ_LEN, 16, maximum words drained per frame; 0 means drain the whole frame.
AW, $clog2(DEPTH), address width; derived, not overridden.

Ports:
E_RXC  in  1  receive clock; the only clock.
rst  in  1  synchronous, active-high reset.
word_valid  in  1  level strobe from UDP core; each 0→1 transition marks one new word.
word_data  in  DATA_W  payload word; sampled in the cycle the rise is detected.
rx_finish  in  1  one-cycle end-of-frame pulse.
out_valid  out  1  drain word valid.
out_data  out  DATA_W  drain word.
out_addr  out  AW  RAM index of out_data.
out_ready  in  1  consumer accepts when out_valid && out_ready.
frame_words  out  AW+1  word count of the last committed frame.
busy  out  1  high when state ≠ IDLE.
overflow  out  1  sticky: a word was dropped in the current or last frame.
done  out  1  one-cycle pulse after the last drain word is accepted.

Behaviour:
- Reset: state IDLE, wr_ptr=0; out_valid, out_data, out_addr, frame_words, busy, overflow and done all 0. Reset mid-drain aborts immediately; RAM contents are don't-care.
- Rise detect: prev <= word_valid; rise = word_valid & ~prev. A strobe held high counts once. prev resets to 0.
- IDLE: on rise, write mem[0] <= word_data, set wr_ptr=1, clear overflow, go to CAPTURE. rx_finish with no words captured is ignored: no done, frame_words unchanged.
- CAPTURE: on rise with wr_ptr<DEPTH, write mem[wr_ptr] and increment wr_ptr. On rise with wr_ptr==DEPTH, drop the word and set overflow; wr_ptr saturates and never wraps.
- CAPTURE commit: on rx_finish, frame_words <= wr_ptr. If rise coincides with rx_finish, the word is written and counted (frame_words = wr_ptr+1, capped at DEPTH). Then n = (READ_LEN==0) ? frame_words : min(frame_words, READ_LEN); rd_ptr=0; go to DRAIN.
- DRAIN: synchronous RAM read with one-cycle latency plus a one-entry output register.
  - First out_valid is exactly 2 cycles after the rx_finish cycle, with out_addr=0.
  - With out_ready held high, words stream back-to-back, one per cycle, addresses 0..n-1.
  - While out_valid && !out_ready, out_data and out_addr hold stable.
  - In the cycle the word at address n-1 is accepted, out_valid deasserts, done pulses for 1 cycle, wr_ptr <= 0, and the state returns to IDLE.
- DRAIN inputs: rises are dropped and set overflow; rx_finish is ignored.
- busy is combinational from state. frame_words and overflow hold until the next frame's first word.

Optional Feature:
Macro ICACHE_LOADER_CSUM_EN.
- Defined: adds output port csum [15:0]. It is the ones-complement sum (end-around carry) of every 16-bit half-word of each word written in the frame, low half first. DATA_W must be a multiple of 16.
  - csum is zeroed on the first word of a frame, updated the cycle after each write, and stable from commit until the next frame starts.
  - Dropped words are excluded.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Defaults. 20 rises with data 0x1000_0000+i, then rx_finish, out_ready=1 → frame_words=20. out_valid first rises 2 cycles after rx_finish; 16 consecutive words 0x1000_0000..0x1000_000F at addr 0..15; done pulses once; busy falls the same cycle.
- READ_LEN=0, DEPTH=8. 10 rises then rx_finish → overflow=1, frame_words=8; drains exactly 8 words, addr 0..7.
- word_valid held high 5 cycles with changing data, then rx_finish → exactly one word is captured (first-cycle value); frame_words=1.
- Back-pressure: during the drain, toggle out_ready 1,0,0,1,… → no word is lost or duplicated; out_data is stable in every stalled cycle; sequence matches writes.
- Rise coincident with rx_finish after 3 prior words → frame_words=4 and the 4th word is drained. rx_finish in IDLE with no words → no done, busy stays 0.
- With ICACHE_LOADER_CSUM_EN: words 0x0001FFFF, 0x00020000 → csum=0x0003. Assert rst mid-drain → all outputs 0 on the next cycle and a new frame captures normally.
